// File: rtl/d3x8_hold.sv
// Registered 3-to-8 decoder with valid/ready handshake, programmable hold time and an eight-line scan mode.
// Optional build macro D3X8_PARITY_EN adds a_par/par_err parity checking on accepted codes.
module d3x8_hold #(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] a,
  input  logic       scan_start,
  output logic [7:0] y,
  output logic       active,
  output logic       done
`ifdef D3X8_PARITY_EN
  ,
  input  logic       a_par,
  output logic       par_err
`endif
);

  typedef enum logic [1:0] {IDLE, HOLD, SCAN} state_t;

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HOLD_CYCLES - 1);

  state_t           state_reg, state_next;
  logic [7:0]       y_reg, y_next;
  logic             active_reg, active_next;
  logic             done_reg, done_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [2:0]       idx_reg, idx_next;
  logic             accept;
  logic             code_ok;

  assign in_ready = (state_reg == IDLE) && en && !rst && !scan_start;
  assign accept   = in_valid && in_ready;

`ifdef D3X8_PARITY_EN
  logic par_err_reg, par_err_next;

  // Valid codes carry odd parity across {a, a_par}; a bad code is still consumed.
  assign code_ok      = ^{a, a_par};
  assign par_err_next = accept && !code_ok;
  assign par_err      = par_err_reg;
`else
  assign code_ok = 1'b1;
`endif

  always_comb begin
    state_next  = state_reg;
    y_next      = y_reg;
    active_next = active_reg;
    done_next   = 1'b0;
    cnt_next    = cnt_reg;
    idx_next    = idx_reg;
    case (state_reg)
      IDLE: begin
        y_next      = 8'h00;
        active_next = 1'b0;
        if (en && scan_start) begin
          state_next  = SCAN;
          y_next      = 8'h01;
          active_next = 1'b1;
          cnt_next    = RELOAD;
          idx_next    = 3'd0;
        end else if (accept && code_ok) begin
          state_next  = HOLD;
          y_next      = 8'h01 << a;
          active_next = 1'b1;
          cnt_next    = RELOAD;
        end
      end
      HOLD, SCAN: begin
        if (!en) begin
          state_next  = IDLE;
          y_next      = 8'h00;
          active_next = 1'b0;
          cnt_next    = '0;
        end else if (cnt_reg != '0) begin
          cnt_next = cnt_reg - CNT_W'(1);
        end else if (state_reg == SCAN && idx_reg != 3'd7) begin
          idx_next = idx_reg + 3'd1;
          y_next   = y_reg << 1;
          cnt_next = RELOAD;
        end else begin
          // Hold expiry, or the last scan line has finished.
          state_next  = IDLE;
          y_next      = 8'h00;
          active_next = 1'b0;
          done_next   = (state_reg == SCAN);
        end
      end
      default: begin
        state_next  = IDLE;
        y_next      = 8'h00;
        active_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      y_reg      <= 8'h00;
      active_reg <= 1'b0;
      done_reg   <= 1'b0;
      cnt_reg    <= '0;
      idx_reg    <= 3'd0;
`ifdef D3X8_PARITY_EN
      par_err_reg <= 1'b0;
`endif
    end else begin
      state_reg  <= state_next;
      y_reg      <= y_next;
      active_reg <= active_next;
      done_reg   <= done_next;
      cnt_reg    <= cnt_next;
      idx_reg    <= idx_next;
`ifdef D3X8_PARITY_EN
      par_err_reg <= par_err_next;
`endif
    end
  end

  assign y      = y_reg;
  assign active = active_reg;
  assign done   = done_reg;

endmodule

// File: tb/tb_d3x8_hold.sv
// Bench for d3x8_hold: two instances (hold 4 and hold 2) share stimulus and are checked every cycle
// against an elapsed-time reference model of the decode/scan timing.
`timescale 1ns/1ps
module tb_d3x8_hold;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, in_valid, scan_start;
  logic [2:0] a;
  logic       rdy [2];
  logic [7:0] yv  [2];
  logic       act [2];
  logic       dn  [2];
`ifdef D3X8_PARITY_EN
  logic       a_par;
  logic       perr [2];
`endif

  d3x8_hold #(.HOLD_CYCLES(4), .CNT_W(8)) u4 (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(rdy[0]),
    .a(a), .scan_start(scan_start), .y(yv[0]), .active(act[0]), .done(dn[0])
`ifdef D3X8_PARITY_EN
    , .a_par(a_par), .par_err(perr[0])
`endif
  );

  d3x8_hold #(.HOLD_CYCLES(2), .CNT_W(8)) u2 (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(rdy[1]),
    .a(a), .scan_start(scan_start), .y(yv[1]), .active(act[1]), .done(dn[1])
`ifdef D3X8_PARITY_EN
    , .a_par(a_par), .par_err(perr[1])
`endif
  );

  int errors = 0;
  int checks = 0;

  // Reference model: mode 0 idle, 1 holding a code, 2 scanning; el = edges since the start edge.
  int   mode [2];
  int   el   [2];
  int   code [2];
  logic done_e [2];
  logic perr_e [2];
  bit   acc  [2];
  int   cnt20;
  int   done_cnt [2];

  function automatic int hc(int i);
    return (i == 0) ? 4 : 2;
  endfunction

  function automatic logic [7:0] exp_y(int i);
    if (mode[i] == 1) return 8'd1 << code[i];
    if (mode[i] == 2) return 8'd1 << (el[i] / hc(i));
    return 8'd0;
  endfunction

  // Loopback through an 8x3 priority encoder.
  function automatic int enc8x3(logic [7:0] v);
    for (int k = 7; k >= 0; k--) if (v[k]) return k;
    return 0;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(int i);
    int dur;
    done_e[i] = 1'b0;
    perr_e[i] = 1'b0;
    acc[i]    = 1'b0;
    dur = (mode[i] == 2) ? 8 * hc(i) : hc(i);
    if (rst) begin
      mode[i] = 0;
    end else if (mode[i] != 0) begin
      if (!en) begin
        mode[i] = 0;
      end else begin
        el[i]++;
        if (el[i] >= dur) begin
          done_e[i] = (mode[i] == 2);
          mode[i]   = 0;
        end
      end
    end else if (en && scan_start) begin
      mode[i] = 2;
      el[i]   = 0;
    end else if (en && in_valid) begin
      acc[i] = 1'b1;
`ifdef D3X8_PARITY_EN
      if (^{a, a_par}) begin
        mode[i] = 1; el[i] = 0; code[i] = a;
      end else begin
        perr_e[i] = 1'b1;
      end
`else
      mode[i] = 1; el[i] = 0; code[i] = a;
`endif
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("in_ready_h%0d", hc(i)), rdy[i], (!rst && en && !scan_start && mode[i] == 0));
      model_edge(i);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("y_h%0d", hc(i)), yv[i], exp_y(i));
      chk($sformatf("active_h%0d", hc(i)), act[i], (exp_y(i) != 8'd0));
      chk($sformatf("done_h%0d", hc(i)), dn[i], done_e[i]);
      chk($sformatf("onehot_h%0d", hc(i)), ($countones(yv[i]) <= 1), 1);
`ifdef D3X8_PARITY_EN
      chk($sformatf("par_err_h%0d", hc(i)), perr[i], perr_e[i]);
`endif
      if (mode[i] == 1) chk($sformatf("loopback_h%0d", hc(i)), enc8x3(yv[i]), code[i]);
      if (dn[i] === 1'b1) done_cnt[i]++;
    end
    if (yv[0] === 8'h20) cnt20++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int n;
    for (int i = 0; i < 2; i++) begin
      mode[i] = 0; el[i] = 0; code[i] = 0;
      done_e[i] = 1'b0; perr_e[i] = 1'b0; acc[i] = 1'b0; done_cnt[i] = 0;
    end
    cnt20 = 0;

    // Reset with a pending valid code.
    rst = 1'b1; en = 1'b1; in_valid = 1'b1; a = 3'd3; scan_start = 1'b0;
`ifdef D3X8_PARITY_EN
    a_par = 1'b1;
`endif
    repeat (2) cycle();
    rst = 1'b0; in_valid = 1'b0;
    cycle();

    // Single decode of a=5.
    cnt20 = 0;
    in_valid = 1'b1; a = 3'd5;
`ifdef D3X8_PARITY_EN
    a_par = 1'b1;
`endif
    cycle();
    in_valid = 1'b0;
    repeat (6) cycle();
    chk("hold_len_a5_h4", cnt20, 4);

    // Every code, waiting for the slower instance to accept each one.
    for (int k = 0; k < 8; k++) begin
      a = 3'(k);
`ifdef D3X8_PARITY_EN
      a_par = ~^a;
`endif
      in_valid = 1'b1;
      n = 0;
      do begin
        cycle();
        n++;
      end while (!acc[0] && n < 20);
      chk($sformatf("accept_code%0d_h4", k), acc[0], 1);
      in_valid = 1'b0;
    end
    repeat (6) cycle();

    // Scan start together with a valid code: scan wins.
    done_cnt[0] = 0; done_cnt[1] = 0;
    scan_start = 1'b1; in_valid = 1'b1; a = 3'd6;
    cycle();
    scan_start = 1'b0; in_valid = 1'b0;
    repeat (8 * 4 + 2) cycle();
    chk("scan_done_h4", done_cnt[0], 1);
    chk("scan_done_h2", done_cnt[1], 1);

    // Abort a scan by dropping en in its third cycle.
    done_cnt[0] = 0; done_cnt[1] = 0;
    scan_start = 1'b1;
    cycle();
    scan_start = 1'b0;
    repeat (2) cycle();
    en = 1'b0;
    cycle();
    chk("abort_y_h4", yv[0], 0);
    chk("abort_y_h2", yv[1], 0);
    en = 1'b1;
    repeat (4) cycle();
    chk("abort_nodone_h4", done_cnt[0], 0);
    chk("abort_nodone_h2", done_cnt[1], 0);

`ifdef D3X8_PARITY_EN
    // Good parity decodes; bad parity is consumed and flagged.
    a = 3'd3; a_par = 1'b1; in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    chk("par_good_y_h4", yv[0], 8'h08);
    repeat (6) cycle();
    a = 3'd3; a_par = 1'b0; in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    chk("par_bad_flag_h4", perr[0], 1);
    chk("par_bad_y_h4", yv[0], 0);
    cycle();
`endif

    // Randomised traffic.
    for (int t = 0; t < 400; t++) begin
      rst        = ($urandom_range(0, 99) == 0);
      en         = ($urandom_range(0, 19) != 0);
      in_valid   = $urandom_range(0, 1);
      a          = 3'($urandom_range(0, 7));
      scan_start = ($urandom_range(0, 29) == 0);
`ifdef D3X8_PARITY_EN
      a_par      = $urandom_range(0, 1);
`endif
      cycle();
    end
    rst = 1'b0; en = 1'b1; in_valid = 1'b0; scan_start = 1'b0;
    repeat (40) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
